// File: rtl/pc_byte_packer_pkg.sv
// Shared types and constants for the PC byte packer: output FSM encoding,
// default inter-byte timeout and the word width used by the completed-word buffer.
package pc_byte_packer_pkg;

    typedef enum logic [1:0] {
        PKR_IDLE   = 2'd0,
        PKR_STROBE = 2'd1,
        PKR_GAP    = 2'd2
    } pkr_state_t;

    localparam int PKR_TIMEOUT_DEFAULT = 65536;
    localparam int PKR_WORD_W          = 32;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/pc_byte_packer_word_fifo.sv
// Completed-word buffer: synchronous FIFO with count-based full/empty,
// a flush that empties it in one edge, and push/pop in the same cycle.
module pc_byte_packer_word_fifo
    import pc_byte_packer_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  push,
    input  logic [PKR_WORD_W-1:0] push_data,
    input  logic                  pop,
    output logic [PKR_WORD_W-1:0] head,
    output logic                  full,
    output logic                  empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [PKR_WORD_W-1:0] mem [DEPTH];
    logic [AW-1:0]         rd_ptr;
    logic [AW-1:0]         wr_ptr;
    logic [CW-1:0]         count;
    logic                  do_push;
    logic                  do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // A full buffer still takes a word when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/pc_byte_packer.sv
// Packs the PC byte stream little-endian into 32-bit words and issues them to
// dword_interface as spaced single-cycle wr strobes, with timeout and error resync.
module pc_byte_packer
    import pc_byte_packer_pkg::*;
#(
    parameter int WR_GAP  = 1,
    parameter int TIMEOUT = PKR_TIMEOUT_DEFAULT,
    parameter int DEPTH   = 2
) (
    input  logic        clk62,
    input  logic        RESET,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [31:0] data_from_PC,
    output logic        wr,
    input  logic        dev_error,
    output logic        resync,
    output logic [1:0]  lane,
    output logic [7:0]  drop_cnt,
    output pkr_state_t  state_dbg
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int GW = (WR_GAP > 1) ? $clog2(WR_GAP) : 1;

    logic [1:0]    lane_q;
    logic [23:0]   partial_q;
    logic [TW-1:0] tmo_cnt;
    logic          err_q;
    logic          resync_q;
    logic [7:0]    drop_q;
    pkr_state_t    state_q;
    logic [GW-1:0] gap_cnt;
    logic [31:0]   data_q;

    logic          accept;
    logic          push;
    logic          pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic [31:0]   fifo_head;
    logic          err_rise;

    // Handshake: a byte transfers on a clock edge where rx_valid && rx_ready;
    // rx_ready never depends on rx_valid, and rx_data must be stable while valid.
    assign rx_ready = !RESET && !(fifo_full && lane_q == 2'd3) && !dev_error;
    assign accept   = rx_valid && rx_ready;
    assign push     = accept && (lane_q == 2'd3);
    assign wr       = (state_q == PKR_STROBE) && !dev_error;
    assign pop      = wr;
    assign err_rise = dev_error && !err_q;

    assign data_from_PC = data_q;
    assign resync       = resync_q;
    assign lane         = lane_q;
    assign drop_cnt     = drop_q;
    assign state_dbg    = state_q;

    pc_byte_packer_word_fifo #(
        .DEPTH(DEPTH)
    ) u_word_fifo (
        .clk      (clk62),
        .rst      (RESET),
        .flush    (dev_error),
        .push     (push),
        .push_data({rx_data, partial_q}),
        .pop      (pop),
        .head     (fifo_head),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    always_ff @(posedge clk62) begin
        if (RESET) begin
            lane_q    <= '0;
            partial_q <= '0;
            tmo_cnt   <= '0;
            err_q     <= 1'b0;
            resync_q  <= 1'b0;
            drop_q    <= '0;
        end else begin
            resync_q <= 1'b0;
            err_q    <= dev_error;
            if (dev_error) begin
                lane_q  <= '0;
                tmo_cnt <= '0;
                if (err_rise && (lane_q != 2'd0 || !fifo_empty)) begin
                    resync_q <= 1'b1;
                    drop_q   <= sat_inc8(drop_q);
                end
            end else if (accept) begin
                case (lane_q)
                    2'd0:    partial_q[7:0]   <= rx_data;
                    2'd1:    partial_q[15:8]  <= rx_data;
                    2'd2:    partial_q[23:16] <= rx_data;
                    default: partial_q        <= partial_q;
                endcase
                lane_q  <= lane_q + 2'd1;
                tmo_cnt <= '0;
            end else if (lane_q != 2'd0) begin
                // An accepted byte takes priority, so expiry only fires on an idle cycle.
                if (tmo_cnt == TW'(TIMEOUT)) begin
                    lane_q   <= '0;
                    tmo_cnt  <= '0;
                    resync_q <= 1'b1;
                    drop_q   <= sat_inc8(drop_q);
                end else begin
                    tmo_cnt <= tmo_cnt + 1'b1;
                end
            end else begin
                tmo_cnt <= '0;
            end
        end
    end

    always_ff @(posedge clk62) begin
        if (RESET) begin
            state_q <= PKR_IDLE;
            gap_cnt <= '0;
            data_q  <= '0;
        end else begin
            case (state_q)
                PKR_IDLE: begin
                    if (!fifo_empty && !dev_error) begin
                        data_q  <= fifo_head;
                        state_q <= PKR_STROBE;
                    end
                end
                PKR_STROBE: begin
                    gap_cnt <= '0;
                    state_q <= dev_error ? PKR_IDLE : PKR_GAP;
                end
                PKR_GAP: begin
                    if (gap_cnt == GW'(WR_GAP - 1)) begin
                        state_q <= PKR_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: state_q <= PKR_IDLE;
            endcase
        end
    end

endmodule

// File: doc/pc_byte_packer.md
Name: pc_byte_packer

Overview:
- Upstream stage of dword_interface; converts the PC byte stream (USB FIFO / UART receiver) into 32-bit words with single-cycle wr strobes.
- Packs bytes little-endian. The first byte lands in [7:0], the position of the CMD code in command words.
- Buffers completed words and spaces the wr pulses by a minimum gap.
- Provides inter-byte timeout resync and discards on a device error.

Parameters:
- WR_GAP, 1: minimum idle cycles between consecutive wr pulses (≥1).
- TIMEOUT, 65536: cycles without a new byte before a partial word is discarded. Counter width is $clog2(TIMEOUT+1).
- DEPTH, 2: completed-word buffer entries (power of two, ≥2).

Ports:
- clk62  in  1  system clock, 62.5 MHz
- RESET  in  1  synchronous, active-high reset
- rx_data  in  8  byte from PC receiver
- rx_valid  in  1  rx_data valid
- rx_ready  out  1  byte accepted when rx_valid & rx_ready
- data_from_PC  out  32  word to dword_interface; valid during wr
- wr  out  1  one-cycle write strobe to dword_interface
- dev_error  in  1  error from dword_interface
- resync  out  1  one-cycle pulse on timeout or error discard
- lane  out  2  bytes held in the current partial word (0..3)
- drop_cnt  out  8  saturating count of discard events

Behaviour:
- Reset (synchronous, active-high; clears everything in the same edge):
  - wr=0, resync=0, lane=0, drop_cnt=0, data_from_PC=0.
  - Buffer empty, gap counter=0, timeout counter=0.
  - rx_ready=0 during reset, and 1 from the first cycle after.
  - Reset mid-word or with words buffered discards them silently. drop_cnt is not incremented.
- Byte accept:
  - rx_ready = !(buffer full && lane==3) && !dev_error.
  - On accept, the byte is stored into partial[8*lane +: 8] and lane increments.
  - When lane==3, the completed word {byte3,byte2,byte1,byte0} is pushed into the buffer and lane wraps to 0.
  - The push happens in the same cycle as the byte accept. A word pushed on cycle N can appear on wr no earlier than cycle N+1.
- Output:
  - States: IDLE, STROBE, GAP.
  - IDLE: if the buffer is non-empty, go to STROBE.
  - STROBE (1 cycle): wr=1, data_from_PC=head word, pop, go to GAP.
  - GAP: hold for WR_GAP cycles with wr=0, then go to IDLE.
  - data_from_PC holds its last value outside STROBE.
  - busy from dword_interface is not a flow-control input; the downstream accepts data words while busy is high. Command sequencing is the PC's responsibility.
  - Push and pop in the same cycle is allowed when full. The occupancy count is unchanged.
- Timeout:
  - The counter runs only while lane≠0. It clears on every accepted byte.
  - When it reaches TIMEOUT: discard the partial word, lane←0, pulse resync, drop_cnt+1 (saturates at 255).
  - Buffered complete words are kept.
  - A byte arriving in the same cycle as expiry wins: it is accepted and no timeout fires.
- dev_error (level):
  - While high: flush the buffer and the partial word (lane←0), hold rx_ready=0, and abort a pending STROBE (no wr that cycle).
  - resync and drop_cnt+1 fire once, on the rising edge of dev_error, only if a partial word or buffered word existed.
  - Normal operation resumes the cycle after dev_error falls.
- Arithmetic: lane is 2-bit and wraps naturally. drop_cnt saturates at 255 and never wraps.

Decomposition:
- defs.vh already holds CMD_* codes. Add:
  - PKR_IDLE / PKR_STROBE / PKR_GAP state encodings.
  - The default TIMEOUT value.
- Sub-module word_fifo: a synchronous FIFO with count-based full/empty, DEPTH entries × 32 bits, simultaneous push/pop. The packer instantiates it once.
- Everything else stays in pc_byte_packer.

Test Plan:
- Bytes 0x9F,0x00,0x00,0x00 back-to-back → one wr with data_from_PC=0x0000009F. wr falls the next cycle. lane returns to 0.
- Command word 0x00014102 followed by 64 words {i,i,i,i}, streamed continuously:
  - 65 wr pulses, each separated by ≥WR_GAP low cycles.
  - Data order preserved.
  - rx_ready drops when the buffer is full and recovers.
  - The N25Qxxx model in the bench observes the page program.
- Two bytes then silence for TIMEOUT cycles:
  - resync pulses once, drop_cnt=1, no wr.
  - The next 4 bytes 0xEF,0xCD,0xAB,0x00 produce 0x00ABCDEF.
- Byte arriving exactly on the expiry cycle → accepted, no resync, lane=3.
- Buffer full plus 1 partial byte, then dev_error high for 3 cycles:
  - No wr is issued.
  - rx_ready=0 throughout.
  - One resync, drop_cnt+1.
  - After dev_error falls, a fresh 4-byte word produces exactly one wr.
- RESET asserted for 1 cycle with lane=2 and 1 buffered word → no wr after release. All outputs are at reset values. drop_cnt=0.
